// File: rtl/if_fetch.sv
// Instruction-fetch stage: fetches 32-bit words as four byte reads,
// assembles them little-endian and presents them to the IF/ID register.
module if_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        branch_interception,
    input  logic [31:0] branch_target,
    input  logic        ifid_stall,
    output logic        if_mem_req,
    output logic [31:0] if_mem_addr,
    input  logic        mem_if_grant,
    input  logic        mem_if_valid,
    input  logic [7:0]  mem_if_data,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst
);

    typedef enum logic {
        FETCH,
        HOLD
    } state_t;

    state_t      state, state_nx;
    logic [31:0] pc, pc_nx;
    logic [31:0] word, word_nx;
    logic [31:0] merged;
    logic [31:0] pc_out_nx, inst_nx;
    logic [2:0]  issue_cnt, issue_nx;
    logic [1:0]  recv_cnt, recv_nx;
    logic        drop, drop_nx;
    logic        granted, consume, take_byte;

    assign if_mem_req  = !rst && (state == FETCH) && !issue_cnt[2];
    assign if_mem_addr = rst ? 32'h0 : pc + {29'b0, issue_cnt};

    assign granted   = if_mem_req && mem_if_grant;
    assign consume   = !ifid_stall && !branch_interception;
    assign take_byte = mem_if_valid && !drop;

    always_comb begin
        merged = word;
        case (recv_cnt)
            2'd0: merged[7:0]   = mem_if_data;
            2'd1: merged[15:8]  = mem_if_data;
            2'd2: merged[23:16] = mem_if_data;
            2'd3: merged[31:24] = mem_if_data;
            default: merged = word;
        endcase
    end

    always_comb begin
        state_nx  = state;
        pc_nx     = pc;
        word_nx   = word;
        issue_nx  = issue_cnt;
        recv_nx   = recv_cnt;
        drop_nx   = drop;
        pc_out_nx = if_pc;
        inst_nx   = if_inst;
        if (branch_interception) begin
            // The byte of a request granted now must not land in the new word
            pc_nx     = branch_target;
            pc_out_nx = 32'h0;
            inst_nx   = 32'h0;
            issue_nx  = 3'd0;
            recv_nx   = 2'd0;
            drop_nx   = granted;
            state_nx  = FETCH;
        end else if (state == HOLD) begin
            if (consume) begin
                pc_out_nx = pc;
                inst_nx   = word;
                pc_nx     = pc + 32'd4;
                issue_nx  = 3'd0;
                recv_nx   = 2'd0;
                state_nx  = FETCH;
            end
        end else begin
            if (mem_if_valid && drop)
                drop_nx = 1'b0;
            if (granted)
                issue_nx = issue_cnt + 3'd1;
            if (take_byte) begin
                word_nx = merged;
                recv_nx = recv_cnt + 2'd1;
            end
            if (take_byte && recv_cnt == 2'd3) begin
                if (if_inst == 32'h0 || consume) begin
                    pc_out_nx = pc;
                    inst_nx   = merged;
                    pc_nx     = pc + 32'd4;
                    issue_nx  = 3'd0;
                    recv_nx   = 2'd0;
                end else begin
                    state_nx = HOLD;
                end
            end else if (consume) begin
                pc_out_nx = 32'h0;
                inst_nx   = 32'h0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= FETCH;
            pc        <= RESET_PC;
            word      <= 32'h0;
            issue_cnt <= 3'd0;
            recv_cnt  <= 2'd0;
            drop      <= 1'b0;
            if_pc     <= 32'h0;
            if_inst   <= 32'h0;
        end else begin
            state     <= state_nx;
            pc        <= pc_nx;
            word      <= word_nx;
            issue_cnt <= issue_nx;
            recv_cnt  <= recv_nx;
            drop      <= drop_nx;
            if_pc     <= pc_out_nx;
            if_inst   <= inst_nx;
        end
    end

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: byte-memory model, transaction-level reference
// model, directed scenarios with literal expectations, then random traffic.
module tb_if_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        bi = 1'b0;
    logic [31:0] bt = 32'h0;
    logic        st = 1'b0;
    logic        g = 1'b0;
    logic        v = 1'b0;
    logic [7:0]  d = 8'h0;
    logic        req;
    logic [31:0] addr, pc_o, inst_o;

    always #5 clk = ~clk;

    if_fetch dut (
        .clk                 (clk),
        .rst                 (rst),
        .branch_interception (bi),
        .branch_target       (bt),
        .ifid_stall          (st),
        .if_mem_req          (req),
        .if_mem_addr         (addr),
        .mem_if_grant        (g),
        .mem_if_valid        (v),
        .mem_if_data         (d),
        .if_pc               (pc_o),
        .if_inst             (inst_o)
    );

    int tests = 0;
    int fails = 0;

    logic [31:0] m_pc, m_spc, m_sinst, m_held, m_raddr;
    logic [7:0]  m_bytes[$];
    int          m_issued;
    bit          m_hold, m_drop, m_resp;
    bit          e_req;
    logic [31:0] e_addr;

    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        logic [31:0] tmp;
        case (a)
            32'd0: return 8'h13;
            32'd1: return 8'h00;
            32'd2: return 8'h00;
            32'd3: return 8'h00;
            32'd4: return 8'h93;
            32'd5: return 8'h00;
            32'd6: return 8'h10;
            32'd7: return 8'h00;
            default: begin
                tmp = a * 32'd37 + 32'd11;
                return tmp[7:0];
            end
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s @%0t: got %h want %h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = 32'h0;
        m_spc = 32'h0;
        m_sinst = 32'h0;
        m_held = 32'h0;
        m_raddr = 32'h0;
        m_bytes.delete();
        m_issued = 0;
        m_hold = 0;
        m_drop = 0;
        m_resp = 0;
    endtask

    // Drive one cycle's inputs and compare DUT against the model.
    task automatic cyc_begin(input bit gi, input bit si, input bit bii,
                             input logic [31:0] ti);
        g = gi;
        st = si;
        bi = bii;
        bt = ti;
        v = m_resp;
        d = m_resp ? mem_byte(m_raddr) : 8'h0;
        #1;
        e_req = !m_hold && m_issued < 4;
        e_addr = m_pc + 32'(m_issued);
        chk("req", {31'b0, req}, {31'b0, e_req});
        if (e_req)
            chk("addr", addr, e_addr);
        chk("if_pc", pc_o, m_spc);
        chk("if_inst", inst_o, m_sinst);
    endtask

    // Advance the model by the rules of the stage, then move to next cycle.
    task automatic cyc_end();
        bit granted, consume;
        logic [31:0] w;
        granted = e_req && g;
        consume = !st && !bi;
        if (bi) begin
            m_pc = bt;
            m_spc = 32'h0;
            m_sinst = 32'h0;
            m_issued = 0;
            m_bytes.delete();
            m_hold = 0;
            m_drop = granted;
        end else if (m_hold) begin
            if (consume) begin
                m_spc = m_pc;
                m_sinst = m_held;
                m_pc = m_pc + 32'd4;
                m_issued = 0;
                m_hold = 0;
            end
        end else begin
            if (v) begin
                if (m_drop) m_drop = 0;
                else m_bytes.push_back(d);
            end
            if (granted) m_issued++;
            if (m_bytes.size() == 4) begin
                w = {m_bytes[3], m_bytes[2], m_bytes[1], m_bytes[0]};
                m_bytes.delete();
                if (m_sinst == 32'h0 || consume) begin
                    m_spc = m_pc;
                    m_sinst = w;
                    m_pc = m_pc + 32'd4;
                    m_issued = 0;
                end else begin
                    m_hold = 1;
                    m_held = w;
                end
            end else if (consume) begin
                m_spc = 32'h0;
                m_sinst = 32'h0;
            end
        end
        m_resp = granted;
        m_raddr = e_addr;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        g = 0; st = 0; bi = 0; v = 0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        model_reset();
        do_reset();

        // Back-to-back fetch, stall into HOLD, redirect with slot full
        for (int c = 0; c <= 20; c++) begin
            cyc_begin(1'b1, (c >= 5 && c <= 14) || c == 16, c == 16,
                      32'h200);
            if (c <= 3) begin
                chk("A addr", addr, 32'(c));
                chk("A req", {31'b0, req}, 32'd1);
            end
            if (c == 4) chk("A req gap", {31'b0, req}, 32'd0);
            if (c == 5) begin
                chk("A pc", pc_o, 32'h0);
                chk("A inst", inst_o, 32'h0000_0013);
                chk("A next addr", addr, 32'h4);
            end
            if (c >= 5 && c <= 14) chk("B stall inst", inst_o, 32'h13);
            if (c == 12) chk("B hold req", {31'b0, req}, 32'd0);
            if (c == 16) begin
                chk("B pc", pc_o, 32'h4);
                chk("B inst", inst_o, 32'h0010_0093);
            end
            if (c == 17) begin
                chk("E inst", inst_o, 32'h0);
                chk("E addr", addr, 32'h200);
                chk("E req", {31'b0, req}, 32'd1);
            end
            cyc_end();
        end

        // Grant withheld in cycles 1-2
        do_reset();
        for (int c = 0; c <= 8; c++) begin
            cyc_begin(!(c == 1 || c == 2), 1'b0, 1'b0, 32'h0);
            if (c == 1 || c == 2) begin
                chk("C addr", addr, 32'h1);
                chk("C req", {31'b0, req}, 32'd1);
            end
            if (c == 6) chk("C early", inst_o, 32'h0);
            if (c == 7) chk("C inst", inst_o, 32'h13);
            cyc_end();
        end

        // Redirect to 0x100 with a grant in the same cycle
        do_reset();
        for (int c = 0; c <= 9; c++) begin
            cyc_begin(1'b1, 1'b0, c == 2, 32'h100);
            if (c == 3) begin
                chk("D addr", addr, 32'h100);
                chk("D req", {31'b0, req}, 32'd1);
            end
            if (c >= 3 && c <= 7) chk("D bubble", inst_o, 32'h0);
            if (c == 8) begin
                chk("D pc", pc_o, 32'h100);
                chk("D inst", inst_o, 32'h7A55_300B);
            end
            cyc_end();
        end

        // Asynchronous reset while byte 2 of the second word returns
        do_reset();
        for (int c = 0; c <= 7; c++) begin
            cyc_begin(1'b1, 1'b1, 1'b0, 32'h0);
            if (c == 7) chk("R full", inst_o, 32'h13);
            cyc_end();
        end
        cyc_begin(1'b1, 1'b1, 1'b0, 32'h0);
        #2 rst = 1'b1;
        v = 1'b0;
        #1;
        chk("R inst", inst_o, 32'h0);
        chk("R pc", pc_o, 32'h0);
        chk("R req", {31'b0, req}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        cyc_begin(1'b1, 1'b0, 1'b0, 32'h0);
        chk("R restart addr", addr, 32'h0);
        chk("R restart req", {31'b0, req}, 32'd1);
        cyc_end();

        // Random traffic against the model
        for (int n = 0; n < 4000; n++) begin
            if (n % 1000 == 0) do_reset();
            cyc_begin($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                      $urandom_range(0, 19) == 0, $urandom);
            cyc_end();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
